// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler: phase codes,
// lamp bundle and the lamp decode used by the scheduler and the display driver.
package intersection_phase_scheduler_pkg;

   // Phase codes as exported on the phase output; code 3'd7 is unused.
   typedef enum logic [2:0] {
      ST_NS_GRN   = 3'd0,
      ST_NS_YEL   = 3'd1,
      ST_AR_1     = 3'd2,
      ST_EW_GRN   = 3'd3,
      ST_EW_YEL   = 3'd4,
      ST_AR_2     = 3'd5,
      ST_PED_WALK = 3'd6
   } phase_e;

   // Road that receives green once the pedestrian walk ends.
   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

   typedef struct packed {
      logic ns_red;
      logic ns_yellow;
      logic ns_green;
      logic ew_red;
      logic ew_yellow;
      logic ew_green;
      logic walk;
   } lamps_t;

   // Lamp decode; any code outside the legal set shows all-red, no walk.
   function automatic lamps_t decode_lamps(input logic [2:0] phase);
      lamps_t l;
      l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
            ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, walk: 1'b0};
      case (phase)
         3'd0: begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
         3'd1: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
         3'd3: begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
         3'd4: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
         3'd6: begin l.walk   = 1'b1; end
         default: begin l.walk = 1'b0; end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/intersection_phase_scheduler_chk.sv
// Safety invariants on the lamp outputs and the scheduler state.
module intersection_phase_scheduler_chk #(
   parameter int CNT_W = 6
) (
   input logic             clk1,
   input logic             reset,
   input logic             ns_red,
   input logic             ns_yellow,
   input logic             ns_green,
   input logic             ew_red,
   input logic             ew_yellow,
   input logic             ew_green,
   input logic             walk,
   input logic [2:0]       phase,
   input logic [CNT_W-1:0] countdown
);

   a_ns_onehot: assert property (@(posedge clk1) disable iff (reset)
      $onehot({ns_red, ns_yellow, ns_green}));

   a_ew_onehot: assert property (@(posedge clk1) disable iff (reset)
      $onehot({ew_red, ew_yellow, ew_green}));

   a_no_conflict: assert property (@(posedge clk1) disable iff (reset)
      !(!ns_red && !ew_red));

   a_walk_safe: assert property (@(posedge clk1) disable iff (reset)
      walk |-> (ns_red && ew_red));

   a_phase_legal: assert property (@(posedge clk1) disable iff (reset)
      phase != 3'd7);

   a_count_nonzero: assert property (@(posedge clk1) disable iff (reset)
      countdown != '0);

endmodule

// File: rtl/intersection_phase_scheduler_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and flags the last count.
module intersection_phase_scheduler_tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk1,
   input  logic reset,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_count;

   assign tick = (r_count == LAST);

   // Prescaler counter, wraps to zero on the tick cycle.
   always_ff @(posedge clk1) begin
      if (reset) begin
         r_count <= '0;
      end else if (tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + PW'(1);
      end
   end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer with a latched pedestrian walk phase.
// Each phase runs for a fixed number of one-second ticks; hold freezes the
// countdown while the prescaler keeps running.
module intersection_phase_scheduler
   import intersection_phase_scheduler_pkg::*;
#(
   parameter int TICK_DIV    = 50_000_000,
   parameter int GREEN_TIME  = 15,
   parameter int YELLOW_TIME = 5,
   parameter int ALLRED_TIME = 2,
   parameter int WALK_TIME   = 10,
   parameter int CNT_W       = 6
) (
   input  logic             clk1,
   input  logic             reset,
   input  logic             ped_req,
   input  logic             hold,
   output logic             ns_red,
   output logic             ns_yellow,
   output logic             ns_green,
   output logic             ew_red,
   output logic             ew_yellow,
   output logic             ew_green,
   output logic             walk,
   output logic             ped_pending,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] countdown,
   output logic             tick
);

   localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_TIME);
   localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_TIME);
   localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_TIME);
   localparam logic [CNT_W-1:0] T_WALK   = CNT_W'(WALK_TIME);

   phase_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pend;
   dir_e             r_dir;

   phase_e           w_state_nxt;
   phase_e           w_succ;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_pend_nxt;
   dir_e             w_dir_nxt;
   logic             w_illegal;
   logic             w_fire;
   logic             w_tick;
   lamps_t           w_lamps;

   // Duration loaded on entry to a phase.
   function automatic logic [CNT_W-1:0] phase_time(input phase_e ph);
      logic [CNT_W-1:0] t;
      case (ph)
         ST_NS_GRN, ST_EW_GRN: t = T_GREEN;
         ST_NS_YEL, ST_EW_YEL: t = T_YELLOW;
         ST_AR_1, ST_AR_2:     t = T_ALLRED;
         ST_PED_WALK:          t = T_WALK;
         default:              t = T_GREEN;
      endcase
      return t;
   endfunction

   intersection_phase_scheduler_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk1  (clk1),
      .reset (reset),
      .tick  (w_tick)
   );

   // Successor of the current phase, used when its countdown expires.
   always_comb begin
      w_succ    = ST_NS_GRN;
      w_illegal = 1'b0;
      case (r_state)
         ST_NS_GRN:   w_succ = ST_NS_YEL;
         ST_NS_YEL:   w_succ = ST_AR_1;
         ST_AR_1:     w_succ = r_pend ? ST_PED_WALK : ST_EW_GRN;
         ST_EW_GRN:   w_succ = ST_EW_YEL;
         ST_EW_YEL:   w_succ = ST_AR_2;
         ST_AR_2:     w_succ = r_pend ? ST_PED_WALK : ST_NS_GRN;
         ST_PED_WALK: w_succ = (r_dir == DIR_EW) ? ST_EW_GRN : ST_NS_GRN;
         default: begin
            w_succ    = ST_NS_GRN;
            w_illegal = 1'b1;
         end
      endcase
   end

   // Next state, countdown, pending latch and walk direction.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_dir_nxt   = r_dir;
      w_fire      = w_tick & ~hold;

      if (w_illegal) begin
         w_state_nxt = ST_NS_GRN;
         w_cnt_nxt   = T_GREEN;
      end else if (w_fire) begin
         if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = w_succ;
            w_cnt_nxt   = phase_time(w_succ);
         end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
      end else begin
         w_cnt_nxt = r_cnt;
      end

      // Entering the walk clears the request; requests during the walk are ignored.
      if ((w_state_nxt == ST_PED_WALK) && (r_state != ST_PED_WALK)) begin
         w_pend_nxt = 1'b0;
      end else if (ped_req && (r_state != ST_PED_WALK)) begin
         w_pend_nxt = 1'b1;
      end else begin
         w_pend_nxt = r_pend;
      end

      if ((w_state_nxt == ST_PED_WALK) && (r_state == ST_AR_1)) begin
         w_dir_nxt = DIR_EW;
      end else if ((w_state_nxt == ST_PED_WALK) && (r_state == ST_AR_2)) begin
         w_dir_nxt = DIR_NS;
      end else begin
         w_dir_nxt = r_dir;
      end
   end

   // Scheduler state registers with synchronous reset.
   always_ff @(posedge clk1) begin
      if (reset) begin
         r_state <= ST_NS_GRN;
         r_cnt   <= T_GREEN;
         r_pend  <= 1'b0;
         r_dir   <= DIR_EW;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         r_dir   <= w_dir_nxt;
      end
   end

   assign w_lamps     = decode_lamps(r_state);
   assign ns_red      = w_lamps.ns_red;
   assign ns_yellow   = w_lamps.ns_yellow;
   assign ns_green    = w_lamps.ns_green;
   assign ew_red      = w_lamps.ew_red;
   assign ew_yellow   = w_lamps.ew_yellow;
   assign ew_green    = w_lamps.ew_green;
   assign walk        = w_lamps.walk;
   assign ped_pending = r_pend;
   assign phase       = r_state;
   assign countdown   = r_cnt;
   assign tick        = w_tick;

   intersection_phase_scheduler_chk #(
      .CNT_W (CNT_W)
   ) u_chk (
      .clk1      (clk1),
      .reset     (reset),
      .ns_red    (ns_red),
      .ns_yellow (ns_yellow),
      .ns_green  (ns_green),
      .ew_red    (ew_red),
      .ew_yellow (ew_yellow),
      .ew_green  (ew_green),
      .walk      (walk),
      .phase     (phase),
      .countdown (countdown)
   );

endmodule
